// File: rtl/gpio_bram_pkg.sv
// Shared types and default widths for the GPIO-to-BRAM capture controller.
package gpio_bram_pkg;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int DIV_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cap_state_e;
endpackage

// File: rtl/sample_rate_div.sv
// Programmable sample divider: strobes once every period+1 enabled cycles.
module sample_rate_div #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 strobe
);
  logic [DIV_WIDTH-1:0] cnt;

  assign strobe = enable && !clear && (cnt == period);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= strobe ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/gpio_bram_capture_ctrl.sv
// Captures GPIO samples into a BRAM at a divided rate (one-shot or circular),
// sharing the BRAM port with a host that yields to capture writes.
module gpio_bram_capture_ctrl
  import gpio_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic                  cfg_wrap,
  input  logic [ADDR_WIDTH-1:0] cfg_depth,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  wrapped,
  output logic                  irq_done
);
  cap_state_e            state, state_n;
  logic                  wrap_q;
  logic [ADDR_WIDTH-1:0] depth_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  wr_pend;
  logic                  strobe;
  logic                  cap_wr;
  logic                  at_last;
  logic                  start_go;
  logic [1:0]            rd_vld;

  sample_rate_div #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clear  (state != RUN),
    .enable (state == RUN),
    .period (div_q),
    .strobe (strobe)
  );

  // A stop in the same cycle as a pending write discards that write.
  assign cap_wr   = wr_pend && !cfg_stop;
  assign at_last  = (wr_ptr == depth_q);
  assign start_go = (state == IDLE) && cfg_start && !cfg_stop;
  assign busy     = (state == RUN);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_go) state_n = RUN;
      RUN: begin
        if (cfg_stop)                        state_n = IDLE;
        else if (cap_wr && at_last && !wrap_q) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      wrap_q   <= 1'b0;
      depth_q  <= '0;
      div_q    <= '0;
      sample_q <= '0;
      wr_pend  <= 1'b0;
      wr_ptr   <= '0;
      wrapped  <= 1'b0;
      irq_done <= 1'b0;
    end else begin
      state <= state_n;
      if (start_go) begin
        wrap_q  <= cfg_wrap;
        depth_q <= cfg_depth;
        div_q   <= cfg_div;
        wr_ptr  <= '0;
        wrapped <= 1'b0;
      end else if (cap_wr) begin
        if (at_last && wrap_q) begin
          wr_ptr  <= '0;
          wrapped <= 1'b1;
        end else begin
          wr_ptr  <= wr_ptr + 1'b1;
        end
      end
      if (strobe) sample_q <= gpio_in;
      // Only queue a write if capture is still running next cycle.
      wr_pend  <= strobe && (state_n == RUN);
      irq_done <= cap_wr && at_last;
    end
  end

  assign host_gnt = host_req && !cap_wr && !ARESET;

  always_comb begin
    bram_en    = cap_wr || host_gnt;
    bram_we    = cap_wr || (host_gnt && host_we);
    bram_addr  = '0;
    bram_wdata = '0;
    if (cap_wr) begin
      bram_addr  = wr_ptr;
      bram_wdata = sample_q;
    end else if (host_gnt) begin
      bram_addr  = host_addr;
      bram_wdata = host_wdata;
    end
  end

  // Read return: grant -> BRAM latency -> registered output.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_vld     <= '0;
      host_rdata <= '0;
    end else begin
      rd_vld <= {rd_vld[0], host_gnt && !host_we};
      if (rd_vld[0]) host_rdata <= bram_rdata;
    end
  end

  assign host_rvalid = rd_vld[1];
endmodule

// File: doc/gpio_bram_capture_ctrl.md
GPIO_BRAM_CAPTURE_CTRL -- requirements
Module: gpio_bram_capture_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- ADDR_WIDTH, 10, BRAM word-address width.
- DATA_WIDTH, 32, GPIO sample and BRAM data width.
- DIV_WIDTH, 16, sample-divider width.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- ACLK  in  1  sole clock; all logic on its rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- cfg_start  in  1  one-cycle pulse; begin capture.
- cfg_stop  in  1  one-cycle pulse; abort capture.
- cfg_wrap  in  1  1 = circular mode, 0 = one-shot.
- cfg_depth  in  ADDR_WIDTH  last capture address; buffer holds cfg_depth+1 words.
- cfg_div  in  DIV_WIDTH  sample period is cfg_div+1 cycles.
- gpio_in  in  DATA_WIDTH  GPIO sample input.
- host_req  in  1  host BRAM access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_gnt  out  1  host access issued this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_WIDTH  host read data.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wdata  out  DATA_WIDTH  BRAM write data.
- bram_rdata  in  DATA_WIDTH  BRAM read data; latency 1 cycle.
- busy  out  1  high in RUN.
- wr_ptr  out  ADDR_WIDTH  next capture address.
- wrapped  out  1  sticky; circular buffer has wrapped at least once since start.
- irq_done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE; DONE SHALL last exactly one cycle and then go to IDLE.
REQ-004 IDLE->RUN SHALL occur on cfg_start; the same edge SHALL latch cfg_wrap, cfg_depth and cfg_div, clear the divider, wr_ptr and wrapped.
REQ-005 In RUN, the divider SHALL count 0..cfg_div_latched; a strobe SHALL fire in the cycle it equals cfg_div_latched, and the divider SHALL then reload to 0. The first strobe SHALL fire cfg_div+1 cycles after the start edge.
REQ-006 On a strobe, gpio_in SHALL be registered into a sample register; the BRAM write (bram_en=1, bram_we=1, bram_addr=wr_ptr) SHALL be issued in the next cycle, and wr_ptr SHALL increment on that write.
REQ-007 One-shot mode: the write to address cfg_depth_latched SHALL move the FSM RUN->DONE; irq_done=1 in DONE.
REQ-008 Circular mode: the write to cfg_depth_latched SHALL wrap wr_ptr to 0, set wrapped, and pulse irq_done for one cycle; the FSM SHALL remain in RUN.
REQ-009 cfg_stop in RUN SHALL go to IDLE without irq_done; a pending sample write SHALL be discarded. If cfg_stop and cfg_start are high together, stop SHALL win. cfg_start in RUN or DONE SHALL be ignored.
REQ-010 Arbitration: a capture write SHALL have absolute priority. host_gnt = host_req AND no capture write this cycle. A stalled host SHALL hold its request.
REQ-011 A granted host access SHALL drive bram_en=1, bram_we=host_we, host_addr and host_wdata in the grant cycle.
REQ-012 For a granted read, host_rvalid SHALL be 1 exactly 2 cycles after the grant, with host_rdata registered from bram_rdata; host_rvalid SHALL be 1 for one cycle per read.
REQ-013 cfg_depth=0 SHALL give a 1-word buffer, with every write completing (one-shot) or wrapping (circular).
REQ-014 When no access is issued, bram_en SHALL be 0 and bram_we SHALL be 0.

Reset
REQ-015 ARESET SHALL asynchronously force IDLE and clear the divider, sample register and read pipeline. All outputs SHALL be 0: host_gnt, host_rvalid, host_rdata, bram_*, busy, wr_ptr, wrapped and irq_done.
REQ-016 Reset asserted mid-RUN SHALL abort capture; no irq_done SHALL be produced.

Structure
REQ-017 Package gpio_bram_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constants.
REQ-018 The divider SHALL be a sub-module, sample_rate_div, with ports clear, enable, period and strobe.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- One-shot: depth=3, div=1, gpio_in incrementing -> writes to addresses 0..3 every 2 cycles; single irq_done; busy falls; host reads return the captured values.
- Circular: depth=1, div=0 -> addresses 0,1,0,1; wrapped set after the first wrap; one irq_done per wrap; cfg_stop -> IDLE with no irq_done.
- Contention: div=0 with continuous host_req -> host_gnt=0 on every capture-write cycle; a host read granted at cycle N gives host_rvalid at N+2 with correct data.
- Stop/start together in RUN -> IDLE; wr_ptr is not reset until the next start.
- ARESET pulse mid-capture -> all outputs 0 asynchronously, no irq_done; a new start captures from address 0.
